// File: rtl/matrix_load_sequencer_pkg.sv
// Shared types and helpers for the matrix load sequencer: FSM state encoding,
// counter width and the run-length clamp.
package matrix_load_pkg;

  localparam int INDEX_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DRAIN   = 3'd2,
    HANDOFF = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Zero or an oversize request both mean "run the full data set".
  function automatic logic [INDEX_W-1:0] clamp_layers(
    input logic [INDEX_W-1:0] n,
    input logic [INDEX_W-1:0] limit
  );
    return ((n == '0) || (n > limit)) ? limit : n;
  endfunction

endpackage

// File: rtl/matrix_load_sequencer_if.sv
// Bundle of the run-control, upstream row stream, storage write and compute
// handoff signals; slave is the sequencer side, master the environment side.
interface matrix_load_sequencer_if #(
  parameter int SIZE  = 3,
  parameter int WIDTH = 32
);
  logic                    start;
  logic [31:0]             num_layers;
  logic                    in_valid;
  logic                    in_ready;
  logic [SIZE*WIDTH-1:0]   in_row;
  logic                    wr_en;
  logic [31:0]             wr_layer;
  logic [31:0]             wr_row;
  logic [SIZE*WIDTH-1:0]   wr_data;
  logic                    layer_ready;
  logic                    compute_ack;
  logic                    busy;
  logic                    done;
  logic [31:0]             stall_cycles;

  modport slave (
    input  start, num_layers, in_valid, in_row, compute_ack,
    output in_ready, wr_en, wr_layer, wr_row, wr_data, layer_ready, busy, done,
           stall_cycles
  );

  modport master (
    output start, num_layers, in_valid, in_row, compute_ack,
    input  in_ready, wr_en, wr_layer, wr_row, wr_data, layer_ready, busy, done,
           stall_cycles
  );
endinterface

// File: rtl/matrix_load_sequencer_counter.sv
// Row/layer index pair for the load sequencer. Row wraps every SIZE rows;
// layer saturates at DATA_SET-1 so it can never address past storage.
module matrix_row_layer_counter
  import matrix_load_pkg::*;
#(
  parameter int SIZE     = 3,
  parameter int DATA_SET = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clr,
  input  logic               i_row_inc,
  input  logic               i_layer_inc,
  input  logic [INDEX_W-1:0] i_last_layer,
  output logic [INDEX_W-1:0] o_row,
  output logic [INDEX_W-1:0] o_layer,
  output logic               o_last_row,
  output logic               o_last_layer
);

  localparam logic [INDEX_W-1:0] ROW_MAX   = INDEX_W'(SIZE - 1);
  localparam logic [INDEX_W-1:0] LAYER_MAX = INDEX_W'(DATA_SET - 1);

  logic [INDEX_W-1:0] r_row;
  logic [INDEX_W-1:0] r_layer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row <= '0;
    end else if (i_clr) begin
      r_row <= '0;
    end else if (i_row_inc) begin
      r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_layer <= '0;
    end else if (i_clr) begin
      r_layer <= '0;
    end else if (i_layer_inc && (r_layer < LAYER_MAX)) begin
      r_layer <= r_layer + 1'b1;
    end
  end

  assign o_row        = r_row;
  assign o_layer      = r_layer;
  assign o_last_row   = (r_row == ROW_MAX);
  assign o_last_layer = (r_layer == i_last_layer);

endmodule

// File: rtl/matrix_load_sequencer.sv
// Streams rows into layered matrix storage and hands each full layer to compute.
// Optional build macro MATRIX_LOAD_STALL_COUNT_EN enables the stall-cycle counter.
module matrix_load_sequencer
  import matrix_load_pkg::*;
#(
  parameter int SIZE     = 3,
  parameter int DATA_SET = 12,
  parameter int WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  matrix_load_sequencer_if.slave  bus
);

  state_t                r_state;
  state_t                w_state_next;
  logic [INDEX_W-1:0]    r_len;
  logic [INDEX_W-1:0]    w_row;
  logic [INDEX_W-1:0]    w_layer;
  logic                  w_last_row;
  logic                  w_last_layer;
  logic                  w_xfer;
  logic                  w_start_acc;
  logic                  w_layer_inc;
  logic                  r_wr_en;
  logic [INDEX_W-1:0]    r_wr_layer;
  logic [INDEX_W-1:0]    r_wr_row;
  logic [SIZE*WIDTH-1:0] r_wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_xfer       = 1'b0;
    w_start_acc  = 1'b0;
    w_layer_inc  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_start_acc  = 1'b1;
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          w_xfer = 1'b1;
          if (w_last_row) begin
            w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        w_state_next = HANDOFF;
      end
      HANDOFF: begin
        if (bus.compute_ack) begin
          if (w_last_layer) begin
            w_state_next = DONE;
          end else begin
            w_layer_inc  = 1'b1;
            w_state_next = LOAD;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Run length is captured once per run so mid-run num_layers changes are inert.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len <= '0;
    end else if (w_start_acc) begin
      r_len <= clamp_layers(bus.num_layers, INDEX_W'(DATA_SET));
    end
  end

  matrix_row_layer_counter #(
    .SIZE     (SIZE),
    .DATA_SET (DATA_SET)
  ) u_counter (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_start_acc),
    .i_row_inc    (w_xfer),
    .i_layer_inc  (w_layer_inc),
    .i_last_layer (r_len - 1'b1),
    .o_row        (w_row),
    .o_layer      (w_layer),
    .o_last_row   (w_last_row),
    .o_last_layer (w_last_layer)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en    <= 1'b0;
      r_wr_layer <= '0;
      r_wr_row   <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        r_wr_layer <= w_layer;
        r_wr_row   <= w_row;
        r_wr_data  <= bus.in_row;
      end
    end
  end

`ifdef MATRIX_LOAD_STALL_COUNT_EN
  logic [31:0] r_stall;
  logic        w_stall;

  assign w_stall = ((r_state == LOAD) && !bus.in_valid) ||
                   ((r_state == HANDOFF) && !bus.compute_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if (w_start_acc) begin
      r_stall <= '0;
    end else if (w_stall && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign bus.stall_cycles = r_stall;
`else
  assign bus.stall_cycles = '0;
`endif

  assign bus.in_ready    = (r_state == LOAD);
  assign bus.layer_ready = (r_state == HANDOFF);
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = (r_state == DONE);
  assign bus.wr_en       = r_wr_en;
  assign bus.wr_layer    = r_wr_layer;
  assign bus.wr_row      = r_wr_row;
  assign bus.wr_data     = r_wr_data;

endmodule

// File: doc/matrix_load_sequencer.md
Name: matrix_load_sequencer

Overview:
- Controller that streams matrix rows from an upstream source into the layered matrix storage.
- Generates write strobe, layer index and row index for each row.
- After each complete layer, hands that layer to the compute engine and waits for its acknowledge before loading the next layer.
- Sits between the input DMA/stream and the matrix storage plus compute engine in the data path.

Parameters:
- size, 3, rows per layer (and elements per row)
- data_set, 12, maximum layers per run
- width, 32, bits per element

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  pulse; begins a run when idle
- num_layers  input  32  layers in this run; sampled when start is accepted
- in_valid  input  1  upstream row valid
- in_ready  output  1  sequencer can accept a row
- in_row  input  size*width  row payload
- wr_en  output  1  storage write strobe, one cycle per row
- wr_layer  output  32  storage layer index for the write
- wr_row  output  32  storage row index for the write
- wr_data  output  size*width  registered row payload
- layer_ready  output  1  current layer is complete in storage
- compute_ack  input  1  compute engine has taken the layer
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at end of run
- stall_cycles  output  32  see Optional Feature

Behaviour:
- States: IDLE, LOAD, DRAIN, HANDOFF, DONE. Outputs are decoded from state or registered; there are no combinational input-to-output paths.
- Reset (async): state=IDLE, layer/row counters=0, wr_en=0, wr_layer=0, wr_row=0, wr_data=0, in_ready=0, layer_ready=0, busy=0, done=0, stall_cycles=0.
- IDLE:
  - On start=1: latch the run length as follows. num_layers=0 or num_layers>data_set is clamped to data_set. Clear counters and go to LOAD.
  - compute_ack is ignored.
- LOAD:
  - in_ready=1.
  - A transfer occurs on an edge where in_valid and in_ready are both 1.
  - Each transfer registers wr_en=1, wr_data=in_row, wr_layer=layer counter, wr_row=row counter. These are visible in the next cycle, so write latency is 1 cycle.
  - Row counter: increments per transfer; wraps to 0 after row size-1.
  - On the transfer of row size-1, go to DRAIN.
- DRAIN:
  - One cycle. in_ready=0. The last row's wr_en is high in this cycle.
  - Next state is HANDOFF.
- HANDOFF:
  - layer_ready=1, in_ready=0. Held until compute_ack=1 is sampled.
  - On ack with the current layer equal to the latched run length minus 1: go to DONE.
  - Otherwise: increment the layer counter and go to LOAD.
- DONE: done=1 for one cycle, then IDLE.
- wr_en is 0 in every cycle not immediately following a transfer.
- start while busy is ignored; num_layers changes mid-run are ignored.
- Layer counter never exceeds data_set-1. Counters are 32-bit unsigned.
- Reset asserted mid-run aborts immediately. Partial layer contents in storage are not cleaned.

Optional Feature:
- Macro: MATRIX_LOAD_STALL_COUNT_EN.
- Defined:
  - stall_cycles counts cycles in LOAD with in_valid=0 plus cycles in HANDOFF with compute_ack=0.
  - Saturates at 2^32-1.
  - Cleared on reset and on accepted start.
- Undefined: stall_cycles is tied to 0 and the counter logic is absent.

Decomposition:
- Package matrix_load_pkg:
  - state enum (IDLE, LOAD, DRAIN, HANDOFF, DONE), 3-bit encoding
  - INDEX_W=32 constant
  - clamp function for num_layers
- Sub-module matrix_row_layer_counter:
  - row/layer counter pair with increment, clear and last-row/last-layer flags
  - instantiated once; the FSM drives its increment/clear

Test Plan (size=3, data_set=12, width=8):
- Basic run: start with num_layers=2, in_valid held 1, compute_ack pulsed 3 cycles after layer_ready.
  - Writes: (layer,row) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), in that order, each wr_en one cycle after its transfer.
  - layer_ready rises one cycle after the last write strobe; done pulses once; busy returns to 0.
- Upstream backpressure: in_valid toggles 1,0,1,0,1 during LOAD.
  - Exactly 3 writes with rows 0,1,2; no wr_en on idle cycles.
  - With macro defined: stall_cycles=2 plus HANDOFF wait cycles.
- Clamp: num_layers=0 and num_layers=20 each produce 12 layers (36 writes); final wr_layer=11.
- Ignored inputs:
  - compute_ack=1 during LOAD has no effect; layer_ready stays 0.
  - start=1 during HANDOFF does not restart the run; counters are unchanged.
- Reset mid-run: assert reset asynchronously (between edges) after (layer,row)=(1,1).
  - All outputs go to 0 immediately.
  - The next start resumes writes at (0,0).
- Handshake hold: in HANDOFF with compute_ack=0 for 10 cycles.
  - layer_ready stays 1 and in_ready stays 0 throughout.
  - Upstream in_valid=1 causes no transfers.
